// File: rtl/adder_pipe.sv
// Pipelined ripple adder: stage k adds operand chunk k, one result per cycle, STAGES-cycle latency.
// Optional signed-overflow output ovf is compiled in with `define ADDER_PIPE_OVF_EN.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Handshake: a transfer happens on a clock edge where in_valid && in_ready
  // (input side) or out_valid && out_ready (output side). The whole pipe moves
  // as one shift register, so it advances whenever the last slot is empty or
  // being consumed; in_ready is that same advance term.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands narrow by one chunk per stage; the sum widens by one chunk.
    localparam int OW = WIDTH - k * CW;

    logic [OW-1:0]         xp;
    logic [OW-1:0]         yp;
    logic                  cp;
    logic                  vp;
    logic [CW:0]           chunk;
    logic [(k+1)*CW-1:0]   s_next;
    logic [(k+1)*CW-1:0]   s_q;
    logic                  c_q;
    logic                  v_q;

    assign chunk = {1'b0, xp[CW-1:0]} + {1'b0, yp[CW-1:0]} + {{CW{1'b0}}, cp};

    if (k == 0) begin : g_head
      assign xp     = x;
      assign yp     = y;
      assign cp     = cin;
      assign vp     = in_valid;
      assign s_next = chunk[CW-1:0];
    end else begin : g_link
      assign xp     = g_stage[k-1].g_fwd.x_q;
      assign yp     = g_stage[k-1].g_fwd.y_q;
      assign cp     = g_stage[k-1].c_q;
      assign vp     = g_stage[k-1].v_q;
      assign s_next = {chunk[CW-1:0], g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= vp;
        c_q <= chunk[CW];
        s_q <= s_next;
      end
    end

    // Upper operand chunks still waiting for their stage.
    if (k < LAST) begin : g_fwd
      logic [OW-CW-1:0] x_q;
      logic [OW-CW-1:0] y_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (advance) begin
          x_q <= xp[OW-1:CW];
          y_q <= yp[OW-1:CW];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign carry     = g_stage[LAST].c_q;

`ifdef ADDER_PIPE_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic ovf_next;
  logic ovf_q;

  assign ovf_next = (g_stage[LAST].xp[CW-1] ^ g_stage[LAST].yp[CW-1] ^ g_stage[LAST].chunk[CW-1])
                    ^ g_stage[LAST].chunk[CW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_next;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and random bench for adder_pipe at WIDTH=16, STAGES=4.
// Checks ovf as well when built with ADDER_PIPE_OVF_EN.
module tb_adder_pipe;

  localparam int W = 16;
  localparam int S = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         cin = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry;
`ifdef ADDER_PIPE_OVF_EN
  logic         ovf;
`endif

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [W:0] exp_q[$];
  logic [W:0] sb_exp;
  logic [W:0] held;
  logic       stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'({carry, sum}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_data", 32'({carry, sum}), 32'(sb_exp));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({1'b0, x} + {1'b0, y} + (W+1)'(cin));
      stall_prev = out_valid && !out_ready;
      held = {carry, sum};
    end
  end

  // driver tasks; all start at posedge+1
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    x = a;
    y = b;
    cin = c;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
  endtask

  logic [W-1:0] b2b_x [3] = '{16'h1234, 16'h00FF, 16'h8000};
  logic [W-1:0] b2b_y [3] = '{16'h1111, 16'h0F01, 16'h8000};
  logic         b2b_c [3] = '{1'b1, 1'b0, 1'b0};
  logic [W:0]   b2b_r [3] = '{17'h02346, 17'h01000, 17'h10000};

  logic [W-1:0] st_x [4] = '{16'h0001, 16'h0F0F, 16'hFFFF, 16'hABCD};
  logic [W-1:0] st_y [4] = '{16'h0002, 16'h00F1, 16'hFFFF, 16'h1234};
  logic         st_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W:0]   st_r [4] = '{17'h00003, 17'h01000, 17'h1FFFF, 17'h0BE01};

  initial begin
    int lat;
    int cnt;
    int sent;
    int cyc;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
`ifdef ADDER_PIPE_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // cross-chunk ripple, accepted on first edge after reset, latency 4
    send(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("ripple_latency", 32'(lat), 32'd4);
    check("ripple_sum", 32'(sum), 32'h0000);
    check("ripple_carry", 32'(carry), 32'd1);

    // back-to-back, one result per cycle in order
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(b2b_x[i], b2b_y[i], b2b_c[i]);
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_result", 32'({carry, sum}), 32'(b2b_r[i]));
      @(negedge clk);
    end
    check("b2b_gap", 32'(out_valid), 32'd0);

    // fill, stall 5 cycles, release
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(st_x[i], st_y[i], st_c[i]);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'({carry, sum}), 32'(st_r[0]));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_result", 32'({carry, sum}), 32'(st_r[i]));
    end
    @(negedge clk);
    check("drain_empty", 32'(out_valid), 32'd0);

    // reset mid-stream discards in-flight work
    @(posedge clk);
    #1;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h0F0F, 16'h0001, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_valid(8, cnt);
    check("midrst_no_ghost", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0005, 16'h0006, 1'b1);
    in_valid = 1'b0;
    wait_out(lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_result", 32'({carry, sum}), 32'h0000C);
    count_valid(6, cnt);
    check("post_rst_single", 32'(cnt), 32'd0);

`ifdef ADDER_PIPE_OVF_EN
    @(posedge clk);
    #1;
    send(16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("ovf_pos_result", 32'({carry, sum}), 32'h08000);
    check("ovf_pos_flag", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    send(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("ovf_wrap_result", 32'({carry, sum}), 32'h10000);
    check("ovf_wrap_flag", 32'(ovf), 32'd0);
`endif

    // random valid/ready traffic against the scoreboard
    @(posedge clk);
    #1;
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      x         = W'($urandom_range(0, 65535));
      y         = W'($urandom_range(0, 65535));
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_sent", 32'(sent), 32'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
